// File: rtl/conv5x5_mac_pkg.sv
// Shared constants, datapath types and window indexing for the 5x5 convolution MAC.
package conv_pkg;

  localparam int WIN_ROWS   = 5;
  localparam int WIN_COLS   = 5;
  localparam int PIX_W      = 8;
  localparam int NUM_TAPS   = WIN_ROWS * WIN_COLS;
  localparam int CENTER_TAP = 12;
  localparam int TAP_AW     = 5;
  localparam int WIN_W      = NUM_TAPS * PIX_W;
  localparam int SHIFT_W    = 4;

  localparam int PROD_W = 17;
  localparam int ROW_W  = 20;
  localparam int SUM_W  = 22;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ROW_W-1:0]  row_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  // Bit offset of pixel w[r][c] inside the flat window bus.
  function automatic int win_idx(input int r, input int c);
    return r * WIN_COLS * PIX_W + c * PIX_W;
  endfunction

endpackage

// File: rtl/conv5x5_mac_if.sv
// Window, kernel-programming and output-pixel signals of the 5x5 convolution MAC.
interface conv5x5_mac_if #(
  parameter int COEF_W = 8
);
  logic [199:0]        i_window;
  logic                i_window_valid;
  logic                i_coef_wr;
  logic [4:0]          i_coef_addr;
  logic [COEF_W-1:0]   i_coef_data;
  logic                i_coef_commit;
  logic [3:0]          i_shift;
  logic [7:0]          o_pixel;
  logic                o_pixel_valid;
  logic                o_line_done;
  logic                o_sat;

  modport master (
    output i_window, i_window_valid, i_coef_wr, i_coef_addr, i_coef_data,
           i_coef_commit, i_shift,
    input  o_pixel, o_pixel_valid, o_line_done, o_sat
  );

  modport slave (
    input  i_window, i_window_valid, i_coef_wr, i_coef_addr, i_coef_data,
           i_coef_commit, i_shift,
    output o_pixel, o_pixel_valid, o_line_done, o_sat
  );
endinterface

// File: rtl/conv5x5_mac_coef_bank.sv
// Double-buffered 5x5 kernel: software fills the shadow bank, a commit copies it
// atomically into the active bank that feeds the MAC pipeline.
module coef_bank
  import conv_pkg::*;
#(
  parameter int COEF_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_coef_wr,
  input  logic [TAP_AW-1:0]          i_coef_addr,
  input  logic [COEF_W-1:0]          i_coef_data,
  input  logic                       i_coef_commit,
  output logic [NUM_TAPS*COEF_W-1:0] o_kernel
);

  localparam logic [TAP_AW-1:0] TAP_LIMIT = TAP_AW'(NUM_TAPS);

  logic signed [COEF_W-1:0] r_shadow     [NUM_TAPS];
  logic signed [COEF_W-1:0] r_active     [NUM_TAPS];
  logic signed [COEF_W-1:0] w_shadow_nxt [NUM_TAPS];

  // A same-cycle commit must see the write, so commit copies the next-state shadow.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    for (int t = 0; t < NUM_TAPS; t++) w_shadow_nxt[t] = r_shadow[t];
    if (i_coef_wr && (i_coef_addr < TAP_LIMIT)) w_shadow_nxt[i_coef_addr] = i_coef_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: these small flop arrays must wake up as an identity kernel, so unlike
      // a RAM they are explicitly reset.
      for (int t = 0; t < NUM_TAPS; t++) begin
        r_shadow[t] <= (t == CENTER_TAP) ? COEF_W'(1) : '0;
        r_active[t] <= (t == CENTER_TAP) ? COEF_W'(1) : '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples
      // pre-edge values.
      r_shadow <= w_shadow_nxt;
      if (i_coef_commit) r_active <= w_shadow_nxt;
    end
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_flat
    assign o_kernel[g*COEF_W +: COEF_W] = r_active[g];
  end

endmodule

// File: rtl/conv5x5_mac.sv
// 5x5 signed-kernel convolution on 8-bit windows: multiply, row sums, total with
// rounding, then shift and saturate to one 8-bit pixel over a 4-stage pipeline.
module conv5x5_mac
  import conv_pkg::*;
#(
  parameter int LINE_W = 512,
  parameter int COEF_W = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  conv5x5_mac_if.slave  io_bus
);

  localparam int                CNT_W    = $clog2(LINE_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LINE_W - 1);

  logic [NUM_TAPS*COEF_W-1:0] w_kernel;

  prod_t              w_prod [NUM_TAPS];
  prod_t              r_prod [NUM_TAPS];
  row_t               w_row  [WIN_ROWS];
  row_t               r_row  [WIN_ROWS];
  sum_t               w_sum;
  sum_t               r_sum;
  sum_t               w_shifted;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_v1, r_v2, r_v3;

  logic [PIX_W-1:0]   w_pix;
  logic               w_sat;
  logic [PIX_W-1:0]   r_pixel;
  logic               r_valid, r_line_done, r_sat;
  logic [CNT_W-1:0]   r_cnt;

  coef_bank #(.COEF_W(COEF_W)) u_coef_bank (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_coef_wr     (io_bus.i_coef_wr),
    .i_coef_addr   (io_bus.i_coef_addr),
    .i_coef_data   (io_bus.i_coef_data),
    .i_coef_commit (io_bus.i_coef_commit),
    .o_kernel      (w_kernel)
  );

  // Pixels are zero-extended to 9-bit signed so they multiply cleanly with signed taps.
  always_comb begin
    for (int r = 0; r < WIN_ROWS; r++) begin
      for (int c = 0; c < WIN_COLS; c++) begin
        w_prod[r*WIN_COLS+c] =
          prod_t'($signed({1'b0, io_bus.i_window[win_idx(r, c) +: PIX_W]})) *
          prod_t'($signed(w_kernel[(r*WIN_COLS+c)*COEF_W +: COEF_W]));
      end
    end
  end

  always_comb begin
    for (int r = 0; r < WIN_ROWS; r++) begin
      w_row[r] = '0;
      for (int c = 0; c < WIN_COLS; c++) w_row[r] = w_row[r] + row_t'(r_prod[r*WIN_COLS+c]);
    end
  end

  always_comb begin
    w_sum = (io_bus.i_shift != '0) ? (sum_t'(1) << (io_bus.i_shift - 4'd1)) : '0;
    for (int r = 0; r < WIN_ROWS; r++) w_sum = w_sum + sum_t'(r_row[r]);
  end

  always_comb begin
    w_shifted = r_sum >>> r_shift;
    w_pix     = w_shifted[PIX_W-1:0];
    w_sat     = 1'b0;
    if (w_shifted[SUM_W-1]) begin
      w_pix = '0;
      w_sat = 1'b1;
    end else if (w_shifted > sum_t'(255)) begin
      w_pix = '1;
      w_sat = 1'b1;
    end
  end

  // NOTE: datapath registers carry no reset; the valid chain alone decides what
  // reaches the output, which keeps reset fan-out off the wide buses.
  always_ff @(posedge i_clk) begin
    if (io_bus.i_window_valid) r_prod <= w_prod;
    if (r_v1) r_row <= w_row;
    if (r_v2) begin
      r_sum   <= w_sum;
      r_shift <= io_bus.i_shift;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_v3        <= 1'b0;
      r_pixel     <= '0;
      r_valid     <= 1'b0;
      r_line_done <= 1'b0;
      r_sat       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_v1 <= io_bus.i_window_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (r_v3) begin
        r_pixel <= w_pix;
        r_valid <= 1'b1;
        r_sat   <= w_sat;
        if (r_cnt == CNT_LAST) begin
          r_cnt       <= '0;
          r_line_done <= 1'b1;
        end else begin
          r_cnt       <= r_cnt + CNT_W'(1);
          r_line_done <= 1'b0;
        end
      end else begin
        r_valid     <= 1'b0;
        r_sat       <= 1'b0;
        r_line_done <= 1'b0;
      end
    end
  end

  assign io_bus.o_pixel       = r_pixel;
  assign io_bus.o_pixel_valid = r_valid;
  assign io_bus.o_line_done   = r_line_done;
  assign io_bus.o_sat         = r_sat;

endmodule

// File: tb/tb_conv5x5_mac.sv
// Self-checking bench for conv5x5_mac: a plain-arithmetic convolution model with a
// 4-cycle expectation queue, checked every cycle, plus directed literal scenarios.
module tb_conv5x5_mac;

  localparam int LINE_W = 512;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv5x5_mac_if #(.COEF_W(8)) bus ();

  conv5x5_mac #(.LINE_W(LINE_W), .COEF_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference convolution straight from the arithmetic definition.
  function automatic int model_pixel(input logic [199:0] w, input int k[25], input int sh,
                                     output bit sat);
    int sum;
    int res;
    sum = 0;
    for (int t = 0; t < 25; t++) sum += int'(w[t*8 +: 8]) * k[t];
    if (sh > 0) sum += (1 << (sh - 1));
    res = sum >>> sh;
    sat = 1'b0;
    if (res < 0) begin res = 0; sat = 1'b1; end
    else if (res > 255) begin res = 255; sat = 1'b1; end
    return res;
  endfunction

  function automatic logic [199:0] uniform_win(input int v);
    logic [199:0] w;
    for (int t = 0; t < 25; t++) w[t*8 +: 8] = 8'(v);
    return w;
  endfunction

  function automatic logic [199:0] rand_win();
    logic [199:0] w;
    for (int t = 0; t < 25; t++) w[t*8 +: 8] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  // Model state: kernel banks and the expectation queue, one entry per accepted cycle.
  typedef struct { bit valid; int pix; bit sat; } exp_t;
  exp_t q[$];
  exp_t pe;
  exp_t ce;
  int   m_shd[25];
  int   m_act[25];
  int   line_cnt;
  int   last_pix;
  bit   exp_ld;
  int   n_out;
  int   done_idx[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int t = 0; t < 25; t++) begin
        m_shd[t] = (t == 12) ? 1 : 0;
        m_act[t] = (t == 12) ? 1 : 0;
      end
    end else begin
      pe.valid = bus.i_window_valid;
      pe.pix   = 0;
      pe.sat   = 1'b0;
      if (pe.valid) pe.pix = model_pixel(bus.i_window, m_act, int'(bus.i_shift), pe.sat);
      q.push_back(pe);
      if (bus.i_coef_wr && bus.i_coef_addr < 5'd25)
        m_shd[bus.i_coef_addr] = int'($signed(bus.i_coef_data));
      if (bus.i_coef_commit) m_act = m_shd;
    end
  end

  always @(negedge clk) begin
    if (bus.o_pixel_valid) begin
      n_out++;
      if (bus.o_line_done) done_idx.push_back(n_out);
    end
    if (!rst_n) begin
      q.delete();
      line_cnt = 0;
      last_pix = 0;
      check("rst_valid", bus.o_pixel_valid == 1'b0, bus.o_pixel_valid, 0);
      check("rst_pixel", bus.o_pixel == 8'd0, bus.o_pixel, 0);
      check("rst_line_done", bus.o_line_done == 1'b0, bus.o_line_done, 0);
      check("rst_sat", bus.o_sat == 1'b0, bus.o_sat, 0);
    end else if (q.size() == 4) begin
      ce = q.pop_front();
      check("cmp_valid", bus.o_pixel_valid == ce.valid, bus.o_pixel_valid, ce.valid);
      if (ce.valid) begin
        line_cnt++;
        exp_ld = (line_cnt == LINE_W);
        if (exp_ld) line_cnt = 0;
        last_pix = ce.pix;
        check("cmp_pixel", int'(bus.o_pixel) == ce.pix, bus.o_pixel, ce.pix);
        check("cmp_sat", bus.o_sat == ce.sat, bus.o_sat, ce.sat);
        check("cmp_line_done", bus.o_line_done == exp_ld, bus.o_line_done, exp_ld);
      end else begin
        check("cmp_hold_pixel", int'(bus.o_pixel) == last_pix, bus.o_pixel, last_pix);
        check("cmp_idle_sat", bus.o_sat == 1'b0, bus.o_sat, 0);
        check("cmp_idle_line_done", bus.o_line_done == 1'b0, bus.o_line_done, 0);
      end
    end else begin
      check("fill_valid", bus.o_pixel_valid == 1'b0, bus.o_pixel_valid, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tap(input int a, input int d);
    bus.i_coef_wr   = 1'b1;
    bus.i_coef_addr = 5'(a);
    bus.i_coef_data = 8'(d);
    tick();
    bus.i_coef_wr   = 1'b0;
  endtask

  task automatic load_kernel(input int k[25]);
    for (int t = 0; t < 25; t++) write_tap(t, k[t]);
    bus.i_coef_commit = 1'b1;
    tick();
    bus.i_coef_commit = 1'b0;
  endtask

  task automatic send_and_check(input logic [199:0] w, input int exp_pix, input bit exp_sat,
                                input string name);
    bus.i_window       = w;
    bus.i_window_valid = 1'b1;
    tick();
    bus.i_window_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, bus.o_pixel_valid == 1'b1, bus.o_pixel_valid, 1);
    check({name, "_pixel"}, int'(bus.o_pixel) == exp_pix, bus.o_pixel, exp_pix);
    check({name, "_sat"}, bus.o_sat == exp_sat, bus.o_sat, exp_sat);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ones_k[25];
    int id_k[25];
    int lap_k[25];
    logic [199:0] w;
    bit s;
    int p;
    int sent;

    for (int t = 0; t < 25; t++) begin
      ones_k[t] = 1;
      id_k[t]   = (t == 12) ? 1 : 0;
      lap_k[t]  = (t == 12) ? 24 : -1;
    end

    // Hand-computed values pinning the reference model.
    p = model_pixel(uniform_win(10), ones_k, 0, s);
    check("pin_box10", p == 250 && s == 1'b0, p, 250);
    p = model_pixel(uniform_win(11), ones_k, 0, s);
    check("pin_box11", p == 255 && s == 1'b1, p, 255);
    p = model_pixel(uniform_win(32), ones_k, 4, s);
    check("pin_box32_sh4", p == 50 && s == 1'b0, p, 50);
    w = uniform_win(100);
    w[12*8 +: 8] = 8'd0;
    p = model_pixel(w, lap_k, 0, s);
    check("pin_lap_neg", p == 0 && s == 1'b1, p, 0);

    bus.i_window       = '0;
    bus.i_window_valid = 1'b0;
    bus.i_coef_wr      = 1'b0;
    bus.i_coef_addr    = '0;
    bus.i_coef_data    = '0;
    bus.i_coef_commit  = 1'b0;
    bus.i_shift        = 4'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pixel_zero", bus.o_pixel == 8'd0, bus.o_pixel, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Identity kernel: centre 0x5A passes through whatever surrounds it.
    for (int i = 0; i < 24; i++) begin
      w = rand_win();
      w[12*8 +: 8] = 8'h5A;
      bus.i_window       = w;
      bus.i_window_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.i_window_valid = 1'b0;
    w = rand_win();
    w[12*8 +: 8] = 8'h5A;
    send_and_check(w, 8'h5A, 1'b0, "identity_5a");

    // Box kernel, unshifted and shifted with rounding.
    load_kernel(ones_k);
    send_and_check(uniform_win(10), 250, 1'b0, "box10");
    send_and_check(uniform_win(11), 255, 1'b1, "box11_sat");
    bus.i_shift = 4'd4;
    send_and_check(uniform_win(200), 255, 1'b1, "box200_sh4_sat");
    send_and_check(uniform_win(32), 50, 1'b0, "box32_sh4");
    bus.i_shift = 4'd0;

    // Laplacian: flat area cancels, dark centre clips low.
    load_kernel(lap_k);
    send_and_check(uniform_win(100), 0, 1'b0, "lap_flat");
    w = uniform_win(100);
    w[12*8 +: 8] = 8'd0;
    send_and_check(w, 0, 1'b1, "lap_neg_sat");

    // Write plus commit in one cycle while streaming: old bank for that window, new after.
    load_kernel(id_k);
    bus.i_window       = uniform_win(7);
    bus.i_window_valid = 1'b1;
    tick();
    bus.i_coef_wr      = 1'b1;
    bus.i_coef_addr    = 5'd12;
    bus.i_coef_data    = 8'd2;
    bus.i_coef_commit  = 1'b1;
    tick();
    bus.i_coef_wr      = 1'b0;
    bus.i_coef_commit  = 1'b0;
    tick();
    bus.i_window_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("commit_pre", int'(bus.o_pixel) == 7, bus.o_pixel, 7);
    @(negedge clk);
    check("commit_same_cycle", int'(bus.o_pixel) == 7, bus.o_pixel, 7);
    @(negedge clk);
    check("commit_after", int'(bus.o_pixel) == 14, bus.o_pixel, 14);
    tick();
    write_tap(30, 5);
    bus.i_coef_commit = 1'b1;
    tick();
    bus.i_coef_commit = 1'b0;
    send_and_check(uniform_win(7), 14, 1'b0, "addr30_ignored");

    // Reset clears the line counter and restores identity; then two full lines.
    load_kernel(ones_k);
    #1 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_out = 0;
    done_idx.delete();
    sent = 0;
    while (sent < 1024) begin
      bus.i_window       = rand_win();
      bus.i_window_valid = ($urandom_range(0, 4) != 0);
      if (bus.i_window_valid) sent++;
      tick();
    end
    bus.i_window_valid = 1'b0;
    repeat (6) tick();
    check("line_outputs", n_out == 1024, n_out, 1024);
    check("line_done_count", done_idx.size() == 2, done_idx.size(), 2);
    if (done_idx.size() == 2) begin
      check("line_done_first", done_idx[0] == 512, done_idx[0], 512);
      check("line_done_second", done_idx[1] == 1024, done_idx[1], 1024);
    end

    // Reset with windows in flight: nothing stale emerges, identity kernel is back.
    load_kernel(ones_k);
    for (int i = 0; i < 3; i++) begin
      bus.i_window       = uniform_win(3);
      bus.i_window_valid = 1'b1;
      tick();
    end
    bus.i_window_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale_valid", bus.o_pixel_valid == 1'b0, bus.o_pixel_valid, 0);
    end
    tick();
    w = rand_win();
    w[12*8 +: 8] = 8'd77;
    send_and_check(w, 77, 1'b0, "identity_after_reset");

    repeat (6) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
